// File: rtl/mac_seq_ctrl.sv
// Sequencing controller for a registered 4-lane MAC wrapper: streams N operand
// chunks into the MAC, feeding its output back as the partial sum, and returns the result.
module mac_seq_ctrl #(
    parameter int unsigned bw      = 4,
    parameter int unsigned psum_bw = 16,
    parameter int unsigned len_bw  = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic [len_bw-1:0]    num_chunk,
    input  logic [psum_bw-1:0]   bias,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [4*bw-1:0]      in_a,
    input  logic [4*bw-1:0]      in_b,
    output logic [4*bw-1:0]      mac_a,
    output logic [4*bw-1:0]      mac_b,
    output logic [psum_bw-1:0]   mac_c,
    input  logic [psum_bw-1:0]   mac_out,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [psum_bw-1:0]   result,
    output logic                 busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [len_bw-1:0]    cnt_q, cnt_d;
    logic [len_bw-1:0]    num_q, num_d;
    logic [psum_bw-1:0]   result_d;
    logic                 out_valid_d;

    // State, counters and registered outputs
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            num_q     <= '0;
            result    <= '0;
            out_valid <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            num_q     <= num_d;
            result    <= result_d;
            out_valid <= out_valid_d;
        end
    end

    // Next-state, register next values and combinational MAC drive
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        num_d       = num_q;
        result_d    = result;
        out_valid_d = out_valid;
        in_ready    = 1'b0;
        busy        = (state_q != IDLE);
        mac_a       = '0;
        mac_b       = '0;
        mac_c       = mac_out;

        case (state_q)
            IDLE: begin
                mac_c = '0;
                if (start) begin
                    mac_c   = bias;
                    num_d   = num_chunk;
                    cnt_d   = '0;
                    state_d = (num_chunk == '0) ? DRAIN : RUN;
                end
            end
            RUN: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    mac_a = in_a;
                    mac_b = in_b;
                    cnt_d = cnt_q + len_bw'(1);
                    if (cnt_d == num_q) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                result_d    = mac_out;
                out_valid_d = 1'b1;
                state_d     = DONE;
            end
            DONE: begin
                out_valid_d = 1'b1;
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Zero drive while in reset so the wrapper flushes on the reset edge
        if (!reset_n) begin
            mac_a = '0;
            mac_b = '0;
            mac_c = '0;
        end
    end

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Bench for mac_seq_ctrl: a behavioural MAC wrapper closes the loop and each job's
// result and latency are checked against a dot-product reference computed here.
module tb_mac_seq_ctrl;

    localparam int unsigned BW  = 4;
    localparam int unsigned PW  = 16;
    localparam int unsigned LW  = 4;
    localparam int unsigned VW  = 4 * BW;

    logic           clk = 1'b0;
    logic           reset_n;
    logic           start;
    logic [LW-1:0]  num_chunk;
    logic [PW-1:0]  bias;
    logic           in_valid;
    logic           in_ready;
    logic [VW-1:0]  in_a;
    logic [VW-1:0]  in_b;
    logic [VW-1:0]  mac_a;
    logic [VW-1:0]  mac_b;
    logic [PW-1:0]  mac_c;
    logic [PW-1:0]  mac_out;
    logic           out_valid;
    logic           out_ready;
    logic [PW-1:0]  result;
    logic           busy;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // job description shared by the scenario tasks and the job driver
    logic [VW-1:0]  ja [16];
    logic [VW-1:0]  jb [16];
    int             jgap [16];
    int             jn;
    logic [PW-1:0]  jbias;
    int             jhold;
    logic [PW-1:0]  bub_q [$];

    mac_seq_ctrl #(.bw(BW), .psum_bw(PW), .len_bw(LW)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .num_chunk (num_chunk),
        .bias      (bias),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .mac_a     (mac_a),
        .mac_b     (mac_b),
        .mac_c     (mac_c),
        .mac_out   (mac_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Registered-input MAC wrapper: out = c + sum(a_i * b_i), unsigned, mod 2^16
    logic [VW-1:0] a_q, b_q;
    logic [PW-1:0] c_q;
    always @(posedge clk) begin
        a_q <= mac_a;
        b_q <= mac_b;
        c_q <= mac_c;
    end
    always_comb begin
        mac_out = c_q;
        for (int i = 0; i < 4; i++)
            mac_out = mac_out + PW'(a_q[i*BW +: BW]) * PW'(b_q[i*BW +: BW]);
    end

    // Reference: bias plus the dot products of all chunks, wrapped to 16 bits
    function automatic logic [PW-1:0] ref_sum();
        int unsigned s;
        s = int'(jbias);
        for (int k = 0; k < jn; k++)
            for (int l = 0; l < 4; l++)
                s += ((int'(ja[k]) >> (4*l)) & 15) * ((int'(jb[k]) >> (4*l)) & 15);
        return s[PW-1:0];
    endfunction

    function automatic int ref_lat();
        int l;
        l = jn + 2;
        for (int k = 0; k < jn; k++) l += jgap[k];
        return l;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_job(input int n, input logic [PW-1:0] b, input int hold);
        jn = n;
        jbias = b;
        jhold = hold;
        for (int k = 0; k < 16; k++) begin
            jgap[k] = 0;
            ja[k] = '0;
            jb[k] = '0;
        end
    endtask

    // Runs the current job from an IDLE cycle and reports what was observed
    task automatic do_job(output logic [PW-1:0] res, output int lat, output int hs,
                          output int hold_bad, output bit idle_ok, output bit tmo);
        int t0;
        bit seen;
        hs = 0; hold_bad = 0; tmo = 0; idle_ok = 0; lat = -1; res = '0; seen = 0;
        bub_q.delete();
        start = 1'b1; num_chunk = LW'(jn); bias = jbias; in_valid = 1'b0; out_ready = 1'b0;
        t0 = cyc;
        step();
        start = 1'b0;
        for (int k = 0; k < jn; k++) begin
            for (int g = 0; g < jgap[k]; g++) begin
                in_valid = 1'b0;
                in_a = VW'($urandom);
                in_b = VW'($urandom);
                start = 1'($urandom);
                bias = PW'($urandom);
                #1;
                if (k > 0) bub_q.push_back(mac_out);
                step();
            end
            in_valid = 1'b1; in_a = ja[k]; in_b = jb[k];
            start = 1'($urandom);
            #1;
            if (in_ready === 1'b1) hs++;
            step();
        end
        in_valid = 1'b1; in_a = VW'($urandom); in_b = VW'($urandom);
        start = 1'b0;
        for (int w = 0; w < 64 && !seen; w++) begin
            if (out_valid === 1'b1) begin
                seen = 1;
                lat = cyc - t0;
                res = result;
            end else begin
                step();
            end
        end
        in_valid = 1'b0;
        if (!seen) begin
            tmo = 1;
            return;
        end
        for (int h = 0; h < jhold; h++) begin
            out_ready = 1'b0;
            start = 1'($urandom);
            in_valid = 1'($urandom);
            #1;
            if (result !== res || in_ready !== 1'b0 || out_valid !== 1'b1 || busy !== 1'b1)
                hold_bad++;
            step();
        end
        out_ready = 1'b1; start = 1'b1; in_valid = 1'b0;
        step();
        out_ready = 1'b0; start = 1'b0;
        #1;
        idle_ok = (busy === 1'b0 && out_valid === 1'b0 && in_ready === 1'b0);
    endtask

    task automatic test_reset();
        reset_n = 1'b0; out_ready = 1'b0;
        for (int c = 0; c < 2; c++) begin
            start = 1'b1; num_chunk = LW'($urandom); bias = PW'($urandom);
            in_valid = 1'($urandom); in_a = VW'($urandom); in_b = VW'($urandom);
            step();
            checks++;
            if (out_valid !== 1'b0 || in_ready !== 1'b0 || busy !== 1'b0) begin
                failures++;
                $display("FAIL reset_flags got ov=%b ir=%b busy=%b exp 0/0/0", out_valid, in_ready, busy);
            end
            checks++;
            if (result !== 16'h0000 || mac_c !== 16'h0000 || mac_a !== 16'h0000) begin
                failures++;
                $display("FAIL reset_values got result=%h mac_c=%h mac_a=%h exp 0", result, mac_c, mac_a);
            end
        end
        reset_n = 1'b1; start = 1'b0; in_valid = 1'b0;
        step();
        checks++;
        if (busy !== 1'b0 || mac_out !== 16'h0000) begin
            failures++;
            $display("FAIL reset_release got busy=%b mac_out=%h exp 0/0000", busy, mac_out);
        end
    endtask

    task automatic check_job(input string name, input logic [PW-1:0] er, input int el,
                             input logic [PW-1:0] gr, input int gl, input int hs,
                             input int hb, input bit idle_ok, input bit tmo);
        checks++;
        if (tmo) begin
            failures++;
            $display("FAIL %s_timeout got no out_valid within bound exp latency %0d", name, el);
        end
        checks++;
        if (gr !== er) begin
            failures++;
            $display("FAIL %s_result got=%0d exp=%0d", name, gr, er);
        end
        checks++;
        if (gl != el) begin
            failures++;
            $display("FAIL %s_latency got=%0d exp=%0d", name, gl, el);
        end
        checks++;
        if (hs != jn) begin
            failures++;
            $display("FAIL %s_handshakes got=%0d exp=%0d", name, hs, jn);
        end
        checks++;
        if (hb != 0) begin
            failures++;
            $display("FAIL %s_hold got=%0d bad cycles exp=0", name, hb);
        end
        checks++;
        if (!idle_ok) begin
            failures++;
            $display("FAIL %s_idle got busy=%b ov=%b after handshake exp idle", name, busy, out_valid);
        end
    endtask

    task automatic test_nominal();
        logic [PW-1:0] r; int l, hs, hb; bit io, tmo;
        clear_job(2, 16'd5, 0);
        ja[0] = 16'h4321; jb[0] = 16'h1111;
        ja[1] = 16'h2222; jb[1] = 16'h3333;
        do_job(r, l, hs, hb, io, tmo);
        check_job("nominal", 16'd39, 4, r, l, hs, hb, io, tmo);
    endtask

    task automatic test_bubbles();
        logic [PW-1:0] r; int l, hs, hb; bit io, tmo;
        clear_job(2, 16'd5, 0);
        ja[0] = 16'h4321; jb[0] = 16'h1111;
        ja[1] = 16'h2222; jb[1] = 16'h3333;
        jgap[1] = 3;
        do_job(r, l, hs, hb, io, tmo);
        check_job("bubbles", 16'd39, 7, r, l, hs, hb, io, tmo);
        checks++;
        if (bub_q.size() != 3) begin
            failures++;
            $display("FAIL bubbles_count got=%0d exp=3", bub_q.size());
        end
        foreach (bub_q[i]) begin
            checks++;
            if (bub_q[i] !== 16'd15) begin
                failures++;
                $display("FAIL bubbles_hold[%0d] got mac_out=%0d exp=15", i, bub_q[i]);
            end
        end
    endtask

    task automatic test_n0_wrap();
        logic [PW-1:0] r; int l, hs, hb; bit io, tmo;
        clear_job(0, 16'd7, 0);
        do_job(r, l, hs, hb, io, tmo);
        check_job("n0", 16'd7, 2, r, l, hs, hb, io, tmo);
        clear_job(1, 16'hFFFF, 1);
        ja[0] = 16'h0001; jb[0] = 16'h0001;
        do_job(r, l, hs, hb, io, tmo);
        check_job("wrap", 16'h0000, 3, r, l, hs, hb, io, tmo);
    endtask

    task automatic test_backpressure();
        logic [PW-1:0] r; int l, hs, hb; bit io, tmo;
        clear_job(3, 16'd100, 5);
        for (int k = 0; k < 3; k++) begin
            ja[k] = VW'($urandom); jb[k] = VW'($urandom);
        end
        do_job(r, l, hs, hb, io, tmo);
        check_job("backpressure", ref_sum(), ref_lat(), r, l, hs, hb, io, tmo);
        clear_job(2, 16'd1, 0);
        ja[0] = 16'h00F3; jb[0] = 16'h0052;
        ja[1] = 16'h7000; jb[1] = 16'h9000;
        do_job(r, l, hs, hb, io, tmo);
        check_job("after_bp", ref_sum(), ref_lat(), r, l, hs, hb, io, tmo);
    endtask

    task automatic test_mid_reset();
        logic [PW-1:0] r; int l, hs, hb; bit io, tmo;
        start = 1'b1; num_chunk = 4'd3; bias = 16'd1234; in_valid = 1'b0; out_ready = 1'b0;
        step();
        start = 1'b0; in_valid = 1'b1; in_a = 16'hFFFF; in_b = 16'hFFFF;
        step();
        reset_n = 1'b0; start = 1'b1;
        step();
        checks++;
        if (busy !== 1'b0 || in_ready !== 1'b0 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL midreset_idle got busy=%b ir=%b ov=%b exp 0/0/0", busy, in_ready, out_valid);
        end
        reset_n = 1'b1; start = 1'b0; in_valid = 1'b0;
        step();
        clear_job(1, 16'd0, 0);
        ja[0] = 16'h1111; jb[0] = 16'h2222;
        do_job(r, l, hs, hb, io, tmo);
        check_job("midreset", 16'd8, 3, r, l, hs, hb, io, tmo);
    endtask

    task automatic test_random();
        logic [PW-1:0] r; int l, hs, hb; bit io, tmo;
        for (int j = 0; j < 8; j++) begin
            clear_job((j == 0) ? 15 : int'($urandom_range(0, 15)), PW'($urandom), int'($urandom_range(0, 3)));
            for (int k = 0; k < jn; k++) begin
                ja[k] = VW'($urandom); jb[k] = VW'($urandom);
                jgap[k] = int'($urandom_range(0, 2));
            end
            do_job(r, l, hs, hb, io, tmo);
            check_job("random", ref_sum(), ref_lat(), r, l, hs, hb, io, tmo);
        end
    endtask

    initial begin
        start = 1'b0; num_chunk = '0; bias = '0; in_valid = 1'b0;
        in_a = '0; in_b = '0; out_ready = 1'b0; reset_n = 1'b0;
        #1;
        test_reset();
        test_nominal();
        test_bubbles();
        test_n0_wrap();
        test_backpressure();
        test_mid_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mac_seq_ctrl.md
# mac_seq_ctrl

Sequencing controller for the registered 4-lane MAC wrapper: accepts a dot-product job (bias plus N four-element chunks), streams chunk operands into the wrapper and feeds its output back as the partial sum. Returns one accumulated result through a valid/ready handshake. Sits between the operand-fetch logic and a single MAC wrapper instance. The MAC wrapper registers its inputs, so its output is valid one cycle after the controller drives them.

## Interface
- `bw`, 4, operand width per lane
- `psum_bw`, 16, partial-sum / result width
- `len_bw`, 4, width of the chunk-count field
- `clk` in 1: clock, rising edge
- `reset_n` in 1: reset, synchronous, active-low; one clock
- `start` in 1: job request; sampled only in IDLE
- `num_chunk` in len_bw: N, the number of 4-lane chunks; latched on an accepted start
- `bias` in psum_bw: initial partial sum; driven to the MAC on the start cycle
- `in_valid` in 1: chunk operands valid
- `in_ready` out 1: controller can take a chunk; equals (state==RUN)
- `in_a` in 4*bw: lane i occupies bits [i*bw +: bw]
- `in_b` in 4*bw: lane i occupies bits [i*bw +: bw]
- `mac_a` out 4*bw: to the wrapper's `a`
- `mac_b` out 4*bw: to the wrapper's `b`
- `mac_c` out psum_bw: to the wrapper's `c`
- `mac_out` in psum_bw: from the wrapper's `out`
- `out_valid` out 1: result valid
- `out_ready` in 1: result consumer ready
- `result` out psum_bw: registered final sum
- `busy` out 1: (state != IDLE)

## Operation
- The controller does no arithmetic itself. Width, sign and wrap (mod 2^psum_bw) are those of the MAC.
- Default MAC drive in every state: `mac_a`=0, `mac_b`=0, `mac_c`=`mac_out`. With these inputs the MAC output is unchanged on the next cycle, so a bubble holds the partial sum.
- States are IDLE, RUN, DRAIN and DONE.
- **IDLE**
  - Drives `mac_c`=0.
  - On `start`: drives `mac_c`=`bias`, latches N and clears the chunk counter.
  - Next state is RUN if N≠0, otherwise DRAIN.
- **RUN**
  - `in_ready`=1.
  - On an `in_valid` handshake: `mac_a`=`in_a`, `mac_b`=`in_b`, `mac_c`=`mac_out`, and the counter increments.
  - The handshake that accepts chunk N moves the block to DRAIN.
  - No handshake means the default drive applies (bubble).
- **DRAIN**
  - `mac_out` now holds the final sum.
  - Captures `mac_out` into `result` and sets `out_valid`. Next state is DONE.
- **DONE**
  - `out_valid`=1 and `result` holds.
  - On `out_ready` the block clears `out_valid` and returns to IDLE. `start` is not sampled on that same cycle.
- `start` outside IDLE is ignored. `in_valid` outside RUN is ignored, because `in_ready`=0.
- Reset (`reset_n`=0 at a clock edge, in any state):
  - State goes to IDLE and the counter to 0.
  - `out_valid`=0, `in_ready`=0, `busy`=0, `result`=0.
  - MAC drive becomes `mac_a`=`mac_b`=0, `mac_c`=0.
  - Any job in flight is discarded. The wrapper's registers flush to 0 on the next clock.

## Timing
- All outputs are registered except `in_ready`, `busy` and the `mac_*` drives, which are combinational from state and inputs.
- Let t0 be the start cycle:
  - Chunks are accepted from cycle t0+1.
  - With `in_valid` held high, chunk k is accepted at t0+k.
  - DRAIN occurs at t0+N+1.
  - `out_valid` rises at t0+N+2.
- For N=0: DRAIN at t0+1, `out_valid` at t0+2.
- Throughput is one chunk per cycle. Each in_valid=0 cycle in RUN adds one cycle of latency.
- Back-to-back jobs: the earliest next start is the cycle after the `out_ready` handshake. The minimum period is N+3 cycles.
- Counter width is len_bw. The maximum N is 2^len_bw − 1 and there is no wrap within a job.

## Test plan
- **Reset:** hold `reset_n`=0 for 2 cycles with random inputs. Required: `out_valid`=`in_ready`=`busy`=0, `result`=0, `mac_c`=0; `start` asserted during reset has no effect.
- **Nominal job:** bias=5, N=2, chunk1 a={1,2,3,4}, b={1,1,1,1}; chunk2 a={2,2,2,2}, b={3,3,3,3}; `in_valid` continuous. Required: `result`=39 and `out_valid` at t0+4.
- **Bubbles:** same job with `in_valid` low for 3 cycles between the chunks. Required: `result`=39, `out_valid` at t0+7, `mac_out` stable at 15 during the bubbles.
- **N=0 and wrap:**
  - bias=7, N=0: `result`=7 at t0+2.
  - bias=16'hFFFF, N=1, a={1,0,0,0}, b={1,0,0,0}: `result`=16'h0000.
- **Backpressure:** `out_ready` low for 5 cycles after `out_valid`. Required: `result` holds, `in_ready`=0, `start` pulses ignored. After `out_ready`: IDLE, and the next job runs correctly.
- **Mid-job reset:** reset asserted after 1 of N=3 chunks. Required: IDLE next cycle, `busy`=0. A following job with bias=0, N=1, a={1,1,1,1}, b={2,2,2,2} yields exactly 8, with no stale sum.
